pipe_hazard_fwd_unit: RTL and testbench

- Parametrised hazard-detection and forwarding unit for the pipelined 16-bit core.
- Keeps its own tag pipeline of in-flight instructions for EX and every downstream stage.
- Outputs the forwarded EX operands, a load-use stall and a multi-cycle branch flush.
- Replaces the hard-wired EX/MEM single-compare forwarding with a depth-generic priority scheme.

---
 rtl/pipe_hazard_fwd_if.sv | 40 ++++
 rtl/pipe_hazard_fwd_unit.sv | 151 +++++++++++++++
 tb/tb_pipe_hazard_fwd_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_fwd_if.sv
// Bundle between the ID/EX stage control of the 16-bit core and the hazard/forwarding unit.
// The master side is the pipeline; the slave side is the hazard/forwarding unit.
interface pipe_hazard_fwd_if #(
    parameter int DW    = 16,
    parameter int RW    = 4,
    parameter int DEPTH = 3
);
    localparam int SW = $clog2(DEPTH);

    logic                    id_vld;
    logic [RW-1:0]           id_rs;
    logic [RW-1:0]           id_rt;
    logic                    id_rs_use;
    logic                    id_rt_use;
    logic [RW-1:0]           id_rd;
    logic                    id_wr;
    logic                    id_is_load;
    logic [DW-1:0]           rf_rs_data;
    logic [DW-1:0]           rf_rt_data;
    logic [(DEPTH-1)*DW-1:0] stage_data;
    logic                    br_taken;
    logic                    stall;
    logic                    flush;
    logic [DW-1:0]           ex_rs_data;
    logic [DW-1:0]           ex_rt_data;
    logic [SW-1:0]           fwd_rs_sel;
    logic [SW-1:0]           fwd_rt_sel;

    modport master (
        output id_vld, id_rs, id_rt, id_rs_use, id_rt_use, id_rd, id_wr, id_is_load,
        output rf_rs_data, rf_rt_data, stage_data, br_taken,
        input  stall, flush, ex_rs_data, ex_rt_data, fwd_rs_sel, fwd_rt_sel
    );

    modport slave (
        input  id_vld, id_rs, id_rt, id_rs_use, id_rt_use, id_rd, id_wr, id_is_load,
        input  rf_rs_data, rf_rt_data, stage_data, br_taken,
        output stall, flush, ex_rs_data, ex_rt_data, fwd_rs_sel, fwd_rt_sel
    );
endinterface

// File: rtl/pipe_hazard_fwd_unit.sv
// Depth-generic hazard detection and operand forwarding for the 16-bit core: tracks in-flight
// instructions from EX to WB, forwards the youngest producer, stalls on load-use, flushes on branches.
module pipe_hazard_fwd_unit #(
    parameter int DW        = 16,
    parameter int RW        = 4,
    parameter int DEPTH     = 3,
    parameter int FLUSH_CYC = 2
) (
    input logic               clk,
    input logic               rst_n,
    pipe_hazard_fwd_if.slave  bus
);
    localparam int SW = $clog2(DEPTH);
    localparam int CW = $clog2(FLUSH_CYC + 1);

    logic [DEPTH-1:0] vld_r;
    logic [DEPTH-1:0] wr_r;
    logic [DEPTH-1:0] ld_r;
    logic [RW-1:0]    rd_r [DEPTH];
    logic [RW-1:0]    rs_r;
    logic [RW-1:0]    rt_r;
    logic             rs_use_r;
    logic             rt_use_r;
    logic [DW-1:0]    op_rs_r;
    logic [DW-1:0]    op_rt_r;
    logic [CW-1:0]    flush_cnt_r;

    logic             flush_s;
    logic             hazard_s;
    logic             stall_s;
    logic             issue_s;
    logic             wb_rs_hit_s;
    logic             wb_rt_hit_s;
    logic [DW-1:0]    wb_res_s;
    logic [SW-1:0]    sel_rs_s;
    logic [SW-1:0]    sel_rt_s;
    logic [DW-1:0]    ex_rs_s;
    logic [DW-1:0]    ex_rt_s;

    // A tracked slot produces src only if it is a live writer of a non-zero register.
    function automatic logic fwd_hit(input logic v, input logic w, input logic [RW-1:0] rd,
                                     input logic [RW-1:0] src);
        return v & w & (rd == src) & (rd != {RW{1'b0}});
    endfunction

    // Hazard, flush and issue decisions; the flush starts in the branch cycle and overrides stall.
    always_comb begin
        flush_s     = bus.br_taken | (flush_cnt_r != {CW{1'b0}});
        hazard_s    = bus.id_vld & vld_r[0] & wr_r[0] & ld_r[0] & (rd_r[0] != {RW{1'b0}}) &
                      ((bus.id_rs_use & (bus.id_rs == rd_r[0])) |
                       (bus.id_rt_use & (bus.id_rt == rd_r[0])));
        stall_s     = hazard_s & ~flush_s;
        issue_s     = bus.id_vld & ~stall_s & ~flush_s;
        wb_res_s    = bus.stage_data[(DEPTH-2)*DW +: DW];
        wb_rs_hit_s = fwd_hit(vld_r[DEPTH-1], wr_r[DEPTH-1], rd_r[DEPTH-1], bus.id_rs);
        wb_rt_hit_s = fwd_hit(vld_r[DEPTH-1], wr_r[DEPTH-1], rd_r[DEPTH-1], bus.id_rt);
    end

    // Priority select: scanning oldest to youngest lets the youngest producer win.
    always_comb begin
        sel_rs_s = {SW{1'b0}};
        sel_rt_s = {SW{1'b0}};
        ex_rs_s  = op_rs_r;
        ex_rt_s  = op_rt_r;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (vld_r[0] & rs_use_r & fwd_hit(vld_r[k], wr_r[k], rd_r[k], rs_r)) begin
                sel_rs_s = SW'(k);
                ex_rs_s  = bus.stage_data[(k-1)*DW +: DW];
            end else begin
                sel_rs_s = sel_rs_s;
                ex_rs_s  = ex_rs_s;
            end
            if (vld_r[0] & rt_use_r & fwd_hit(vld_r[k], wr_r[k], rd_r[k], rt_r)) begin
                sel_rt_s = SW'(k);
                ex_rt_s  = bus.stage_data[(k-1)*DW +: DW];
            end else begin
                sel_rt_s = sel_rt_s;
                ex_rt_s  = ex_rt_s;
            end
        end
    end

    // Tag pipeline: slot 0 takes the ID instruction or a bubble, older slots shift down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= {DEPTH{1'b0}};
            wr_r  <= {DEPTH{1'b0}};
            ld_r  <= {DEPTH{1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                rd_r[k] <= {RW{1'b0}};
            end
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                vld_r[k] <= vld_r[k-1];
                wr_r[k]  <= wr_r[k-1];
                ld_r[k]  <= ld_r[k-1];
                rd_r[k]  <= rd_r[k-1];
            end
            vld_r[0] <= issue_s;
            wr_r[0]  <= issue_s & bus.id_wr;
            ld_r[0]  <= issue_s & bus.id_is_load;
            rd_r[0]  <= bus.id_rd;
        end
    end

    // EX source tags and operands; WB results are written through since the RF read missed them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_r     <= {RW{1'b0}};
            rt_r     <= {RW{1'b0}};
            rs_use_r <= 1'b0;
            rt_use_r <= 1'b0;
            op_rs_r  <= {DW{1'b0}};
            op_rt_r  <= {DW{1'b0}};
        end else if (issue_s) begin
            rs_r     <= bus.id_rs;
            rt_r     <= bus.id_rt;
            rs_use_r <= bus.id_rs_use;
            rt_use_r <= bus.id_rt_use;
            op_rs_r  <= wb_rs_hit_s ? wb_res_s : bus.rf_rs_data;
            op_rt_r  <= wb_rt_hit_s ? wb_res_s : bus.rf_rt_data;
        end else begin
            rs_r     <= rs_r;
            rt_r     <= rt_r;
            rs_use_r <= 1'b0;
            rt_use_r <= 1'b0;
            op_rs_r  <= op_rs_r;
            op_rt_r  <= op_rt_r;
        end
    end

    // Flush counter covers the cycles after the branch cycle; a new branch restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_r <= {CW{1'b0}};
        end else if (bus.br_taken) begin
            flush_cnt_r <= CW'(FLUSH_CYC - 1);
        end else if (flush_cnt_r != {CW{1'b0}}) begin
            flush_cnt_r <= flush_cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            flush_cnt_r <= flush_cnt_r;
        end
    end

    assign bus.stall      = stall_s;
    assign bus.flush      = flush_s;
    assign bus.fwd_rs_sel = sel_rs_s;
    assign bus.fwd_rt_sel = sel_rt_s;
    assign bus.ex_rs_data = ex_rs_s;
    assign bus.ex_rt_data = ex_rt_s;
endmodule

// File: tb/tb_pipe_hazard_fwd_unit.sv
// Directed table-driven bench for pipe_hazard_fwd_unit (DEPTH = 3, FLUSH_CYC = 2), plus a
// hand-written reset-mid-stream sequence.
module tb_pipe_hazard_fwd_unit;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    pipe_hazard_fwd_if #(.DW(16), .RW(4), .DEPTH(3)) bus ();

    pipe_hazard_fwd_unit #(.DW(16), .RW(4), .DEPTH(3), .FLUSH_CYC(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [3:0]  rs, rt;
        logic        rsu, rtu;
        logic [3:0]  rd;
        logic        wr, ld;
        logic [15:0] rf_rs, rf_rt, sd1, sd2;
        logic        br;
        logic        e_stall, e_flush;
        logic [1:0]  e_srs, e_srt;
        logic        chk_d;
        logic [15:0] e_drs, e_drt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic vld, input logic [3:0] rs, input logic [3:0] rt,
                       input logic rsu, input logic rtu, input logic [3:0] rd,
                       input logic wr, input logic ld, input logic [15:0] rf_rs,
                       input logic [15:0] rf_rt, input logic [15:0] sd1, input logic [15:0] sd2,
                       input logic br, input logic e_stall, input logic e_flush,
                       input logic [1:0] e_srs, input logic [1:0] e_srt, input logic chk_d,
                       input logic [15:0] e_drs, input logic [15:0] e_drt);
        vec_t v;
        v = '{vld, rs, rt, rsu, rtu, rd, wr, ld, rf_rs, rf_rt, sd1, sd2, br,
              e_stall, e_flush, e_srs, e_srt, chk_d, e_drs, e_drt};
        tbl.push_back(v);
    endtask

    task automatic idle(input logic [15:0] sd1, input logic [15:0] sd2, input logic br,
                        input logic e_flush, input logic [1:0] e_srs, input logic chk_d,
                        input logic [15:0] e_drs, input logic [15:0] e_drt);
        add(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, sd1, sd2, br,
            1'b0, e_flush, e_srs, 2'd0, chk_d, e_drs, e_drt);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.id_vld     = v.vld;
        bus.id_rs      = v.rs;
        bus.id_rt      = v.rt;
        bus.id_rs_use  = v.rsu;
        bus.id_rt_use  = v.rtu;
        bus.id_rd      = v.rd;
        bus.id_wr      = v.wr;
        bus.id_is_load = v.ld;
        bus.rf_rs_data = v.rf_rs;
        bus.rf_rt_data = v.rf_rt;
        bus.stage_data = {v.sd2, v.sd1};
        bus.br_taken   = v.br;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".stall"}, {15'd0, bus.stall}, 16'h0000);
        chk({tag, ".flush"}, {15'd0, bus.flush}, 16'h0000);
        chk({tag, ".sel_rs"}, {14'd0, bus.fwd_rs_sel}, 16'h0000);
        chk({tag, ".sel_rt"}, {14'd0, bus.fwd_rt_sel}, 16'h0000);
        chk({tag, ".ex_rs"}, bus.ex_rs_data, 16'h0000);
        chk({tag, ".ex_rt"}, bus.ex_rt_data, 16'h0000);
    endtask

    initial begin
        vec_t z;
        n_chk  = 0;
        n_fail = 0;
        z = '{1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0,
              1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 16'h0, 16'h0};

        // Cycle-by-cycle vectors: ID instruction, RF/stage data, branch, expected outputs.
        // c0-c4: back-to-back ADD r3 -> ADD r4 = r3 + r1 forwards from slot 1.
        add(1, 1, 2, 1, 1, 3, 1, 0, 16'h0011, 16'h0022, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000);
        add(1, 3, 1, 1, 1, 4, 1, 0, 16'h0000, 16'h0011, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 1, 16'h0011, 16'h0022);
        idle(16'h1234, 16'h0000, 0, 0, 1, 1, 16'h1234, 16'h0011);
        idle(16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000);
        idle(16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000);
        // c5-c10: r3 produced in slots 1 and 2, youngest (slot 1) wins; rt unused is not forwarded.
        add(1, 1, 2, 1, 1, 3, 1, 0, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        add(1, 1, 2, 1, 1, 3, 1, 0, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 1, 16'h0001, 16'h0002);
        add(1, 3, 3, 1, 0, 5, 1, 0, 16'h0000, 16'h0777, 16'h1111, 16'h0000, 0, 0, 0, 0, 0, 1, 16'h0001, 16'h0002);
        idle(16'hAAAA, 16'h5555, 0, 0, 1, 1, 16'hAAAA, 16'h0777);
        idle(16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000);
        idle(16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000);
        // c11-c16: LW r5 then ADD using r5: one stall cycle, then the load result arrives from WB.
        add(1, 1, 0, 1, 0, 5, 1, 1, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        add(1, 5, 2, 1, 1, 6, 1, 0, 16'h0000, 16'h0002, 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 1, 16'h0010, 16'h0000);
        add(1, 5, 2, 1, 1, 6, 1, 0, 16'h0000, 16'h0002, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        idle(16'h0000, 16'hCAFE, 0, 0, 2, 1, 16'hCAFE, 16'h0002);
        idle(16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000);
        idle(16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000);
        // c17-c21: single branch flushes 2 cycles; the held instruction issues afterwards.
        add(1, 9, 10, 1, 1, 8, 1, 0, 16'h0009, 16'h000A, 16'h0000, 16'h0000, 1, 0, 1, 0, 0, 0, 16'h0000, 16'h0000);
        add(1, 9, 10, 1, 1, 8, 1, 0, 16'h0009, 16'h000A, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000);
        add(1, 9, 10, 1, 1, 8, 1, 0, 16'h0009, 16'h000A, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        idle(16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0009, 16'h000A);
        idle(16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000);
        // c22-c25: branch again in flush cycle 2 stretches flush to 3 cycles.
        idle(16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000, 16'h0000);
        idle(16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000, 16'h0000);
        idle(16'h0000, 16'h0000, 0, 1, 0, 0, 16'h0000, 16'h0000);
        idle(16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000);
        // c26-c31: branch coinciding with a load-use hazard: flush now, stall suppressed.
        add(1, 1, 0, 1, 0, 5, 1, 1, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        add(1, 5, 2, 1, 1, 6, 1, 0, 16'h0000, 16'h0002, 16'h0000, 16'h0000, 1, 0, 1, 0, 0, 1, 16'h0010, 16'h0000);
        add(1, 5, 2, 1, 1, 6, 1, 0, 16'h0000, 16'h0002, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000);
        idle(16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000);
        idle(16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000);
        idle(16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000);
        // c32-c36: WB writes r7 = BEEF while ID reads r7 and r0: write-through for r7 only.
        add(1, 1, 2, 1, 1, 7, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        idle(16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000);
        idle(16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000);
        add(1, 7, 0, 1, 1, 9, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        idle(16'h0000, 16'h1111, 0, 0, 0, 1, 16'hBEEF, 16'h0000);
        // c37-c41: a writer of r0 is neither forwarded from MEM nor written through from WB.
        add(1, 1, 2, 1, 1, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        add(1, 0, 0, 1, 1, 10, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        idle(16'hDEAD, 16'h0000, 0, 0, 0, 1, 16'h0000, 16'h0000);
        add(1, 0, 0, 1, 1, 11, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        idle(16'hDEAD, 16'hBEEF, 0, 0, 0, 1, 16'h0000, 16'h0000);

        // Power-on reset.
        rst_n = 1'b0;
        drive(z);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(negedge clk);
            chk($sformatf("v%0d.stall", i), {15'd0, bus.stall}, {15'd0, tbl[i].e_stall});
            chk($sformatf("v%0d.flush", i), {15'd0, bus.flush}, {15'd0, tbl[i].e_flush});
            chk($sformatf("v%0d.sel_rs", i), {14'd0, bus.fwd_rs_sel}, {14'd0, tbl[i].e_srs});
            chk($sformatf("v%0d.sel_rt", i), {14'd0, bus.fwd_rt_sel}, {14'd0, tbl[i].e_srt});
            if (tbl[i].chk_d) begin
                chk($sformatf("v%0d.ex_rs", i), bus.ex_rs_data, tbl[i].e_drs);
                chk($sformatf("v%0d.ex_rt", i), bus.ex_rt_data, tbl[i].e_drt);
            end
            @(posedge clk);
            #1;
        end

        // Reset mid-stream: ADD r1, LW r5 <- r1 in flight, dependent ADD stalled in ID.
        drive('{1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 16'h0002, 16'h0003,
                16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 16'h0, 16'h0});
        @(posedge clk);
        #1;
        drive('{1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b1, 16'h0010, 16'h0020,
                16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 16'h0, 16'h0});
        @(posedge clk);
        #1;
        drive('{1'b1, 4'd5, 4'd2, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 16'h0000, 16'h0002,
                16'h7777, 16'h0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 16'h0, 16'h0});
        @(negedge clk);
        chk("mid.stall_before", {15'd0, bus.stall}, 16'h0001);
        chk("mid.sel_rs_before", {14'd0, bus.fwd_rs_sel}, 16'h0001);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive('{1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 16'h4321, 16'h8765,
                16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 16'h0, 16'h0});
        @(posedge clk);
        #1;
        drive(z);
        bus.stage_data = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("post_reset.sel_rs", {14'd0, bus.fwd_rs_sel}, 16'h0000);
        chk("post_reset.sel_rt", {14'd0, bus.fwd_rt_sel}, 16'h0000);
        chk("post_reset.ex_rs", bus.ex_rs_data, 16'h4321);
        chk("post_reset.ex_rt", bus.ex_rt_data, 16'h8765);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
